// File: rtl/rat_int_ctrl.sv
// ============================================================================
// rat_int_ctrl : prioritized edge-triggered interrupt controller for RAT INT_CU
// Rev 1.0
// ============================================================================
`default_nettype none

module rat_int_ctrl #(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] MASK_PORT = 8'h20,
    parameter logic [7:0] PEND_PORT = 8'h21,
    parameter logic [7:0] ID_PORT   = 8'h22
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    input  logic             INT_ACK,
    output logic             INT_CU,
    output logic [7:0]       RD_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_SRC-1:0] s1_q, s1_d;
    logic [N_SRC-1:0] s2_q, s2_d;
    logic [N_SRC-1:0] s3_q, s3_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [2:0]       active_id_q, active_id_d;
    logic             int_cu_q, int_cu_d;

    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] ack_clr;
    logic [2:0]       winner;
    logic             wr_mask;
    logic             wr_pend;
    logic             wr_eoi;
    logic [7:0]       mask_rd;
    logic [7:0]       pend_rd;
    logic             unused_out_bits;

    assign unused_out_bits = ^OUT_PORT;

    assign wr_mask = IO_STRB && (PORT_ID == MASK_PORT);
    assign wr_pend = IO_STRB && (PORT_ID == PEND_PORT);
    assign wr_eoi  = IO_STRB && (PORT_ID == ID_PORT);

    // s1/s2 resolve metastability; s3 remembers the previous synchronized level
    always_comb begin
        s1_d     = IRQ;
        s2_d     = s1_q;
        s3_d     = s2_q;
        edge_det = s2_q & ~s3_q;
    end

    assign eligible = pend_q & mask_q;

    always_comb begin
        winner = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        ack_clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d     = ST_REQ;
                    active_id_d = winner;
                end
            end
            ST_REQ: begin
                if (INT_ACK) begin
                    state_d = ST_SERVICE;
                    for (int i = 0; i < N_SRC; i++) begin
                        ack_clr[i] = (active_id_q == 3'(i));
                    end
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        int_cu_d = (state_d == ST_REQ);
    end

    // A fresh edge overrides any clear landing on the same bit
    always_comb begin
        w1c_clr = wr_pend ? OUT_PORT[N_SRC-1:0] : '0;
        mask_d  = wr_mask ? OUT_PORT[N_SRC-1:0] : mask_q;
        pend_d  = (pend_q & ~(w1c_clr | ack_clr)) | edge_det;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            active_id_q <= 3'd0;
            int_cu_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            active_id_q <= active_id_d;
            int_cu_q    <= int_cu_d;
        end
    end

    assign INT_CU = int_cu_q;

    always_comb begin
        mask_rd               = 8'h00;
        mask_rd[N_SRC-1:0]    = mask_q;
        pend_rd               = 8'h00;
        pend_rd[N_SRC-1:0]    = pend_q;
        case (PORT_ID)
            MASK_PORT: RD_DATA = mask_rd;
            PEND_PORT: RD_DATA = pend_rd;
            ID_PORT:   RD_DATA = {(state_q == ST_SERVICE), 4'b0000, active_id_q};
            default:   RD_DATA = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rat_int_ctrl.sv
// ============================================================================
// tb_rat_int_ctrl : directed bench for rat_int_ctrl with a cycle-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rat_int_ctrl;

    localparam int         N_SRC     = 4;
    localparam logic [7:0] MASK_PORT = 8'h20;
    localparam logic [7:0] PEND_PORT = 8'h21;
    localparam logic [7:0] ID_PORT   = 8'h22;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [N_SRC-1:0] IRQ;
    logic [7:0]       PORT_ID;
    logic [7:0]       OUT_PORT;
    logic             IO_STRB;
    logic             INT_ACK;
    logic             INT_CU;
    logic [7:0]       RD_DATA;

    rat_int_ctrl #(
        .N_SRC     (N_SRC),
        .MASK_PORT (MASK_PORT),
        .PEND_PORT (PEND_PORT),
        .ID_PORT   (ID_PORT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IRQ      (IRQ),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .INT_ACK  (INT_ACK),
        .INT_CU   (INT_CU),
        .RD_DATA  (RD_DATA)
    );

    always #10 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // IRQ level captured at every edge; a source fires when the level seen
    // two edges ago is high and the one three edges ago was low.
    bit [N_SRC-1:0] irq_hist [0:8191];
    int             m_cyc  = 0;
    bit             m_live = 1'b0;
    bit [N_SRC-1:0] m_mask = '0;
    bit [N_SRC-1:0] m_pend = '0;
    bit             m_req  = 1'b0;
    bit             m_svc  = 1'b0;
    int             m_id   = 0;

    function automatic bit [N_SRC-1:0] hist(input int k);
        if (k < 0) return '0;
        return irq_hist[k];
    endfunction

    function automatic logic [7:0] m_rd(input logic [7:0] p);
        logic [7:0] r;
        r = 8'h00;
        if (p == MASK_PORT)      r[N_SRC-1:0] = m_mask;
        else if (p == PEND_PORT) r[N_SRC-1:0] = m_pend;
        else if (p == ID_PORT)   r = {m_svc, 4'b0000, m_id[2:0]};
        return r;
    endfunction

    always @(posedge CLK) begin
        bit [N_SRC-1:0] fired;
        bit [N_SRC-1:0] clr;
        bit [N_SRC-1:0] elig;
        int             win;
        if (RESET) begin
            m_live = 1'b1;
            m_mask = '0;
            m_pend = '0;
            m_req  = 1'b0;
            m_svc  = 1'b0;
            m_id   = 0;
            irq_hist[m_cyc] = '0;
        end else begin
            fired = hist(m_cyc - 2) & ~hist(m_cyc - 3);
            clr   = (IO_STRB && PORT_ID == PEND_PORT) ? OUT_PORT[N_SRC-1:0] : '0;
            elig  = m_pend & m_mask;
            if (!m_req && !m_svc) begin
                if (elig != 0) begin
                    win = 0;
                    for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) win = i;
                    m_req = 1'b1;
                    m_id  = win;
                end
            end else if (m_req) begin
                if (INT_ACK) begin
                    m_req = 1'b0;
                    m_svc = 1'b1;
                    clr[m_id] = 1'b1;
                end
            end else begin
                if (IO_STRB && PORT_ID == ID_PORT) m_svc = 1'b0;
            end
            if (IO_STRB && PORT_ID == MASK_PORT) m_mask = OUT_PORT[N_SRC-1:0];
            m_pend = (m_pend & ~clr) | fired;
            irq_hist[m_cyc] = IRQ;
        end
        m_cyc++;
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (m_live) begin
            chk("cyc_int_cu", {7'b0, INT_CU}, {7'b0, m_req});
            chk("cyc_rd_data", RD_DATA, m_rd(PORT_ID));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        PORT_ID  = port;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] port, input logic [7:0] exp);
        PORT_ID = port;
        #1;
        chk(name, RD_DATA, exp);
        chk({name, "_model"}, m_rd(port), exp);
    endtask

    task automatic cu(input string name, input logic exp);
        chk(name, {7'b0, INT_CU}, {7'b0, exp});
        chk({name, "_model"}, {7'b0, m_req}, {7'b0, exp});
    endtask

    initial begin
        RESET    = 1'b1;
        IRQ      = '0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        IO_STRB  = 1'b0;
        INT_ACK  = 1'b0;
        repeat (3) tick();
        cu("rst_int_cu", 1'b0);
        rd("rst_mask", MASK_PORT, 8'h00);
        rd("rst_pend", PEND_PORT, 8'h00);
        rd("rst_id", ID_PORT, 8'h00);
        RESET = 1'b0;

        // Masked source pends but does not request; enabling it requests
        IRQ = 4'b0001; tick(); IRQ = '0; repeat (5) tick();
        rd("t1_pend", PEND_PORT, 8'h01);
        cu("t1_masked_cu", 1'b0);
        wr(MASK_PORT, 8'h01);
        cu("t1_cu_strobe_edge", 1'b0);
        tick();
        cu("t1_cu_second_edge", 1'b1);
        rd("t1_id_req", ID_PORT, 8'h00);
        ack();
        cu("t1_cu_after_ack", 1'b0);
        rd("t1_id_svc", ID_PORT, 8'h80);
        rd("t1_pend_after_ack", PEND_PORT, 8'h00);
        wr(ID_PORT, 8'h00);
        rd("t1_id_after_eoi", ID_PORT, 8'h00);

        // Two sources on the same edge: lowest index first
        wr(MASK_PORT, 8'h0F);
        IRQ = 4'b0110; tick(); IRQ = '0; tick(); tick();
        cu("t2_cu_t0p2", 1'b0);
        tick();
        cu("t2_cu_t0p3", 1'b1);
        rd("t2_id_req", ID_PORT, 8'h01);
        ack();
        rd("t2_pend_ack", PEND_PORT, 8'h04);
        rd("t2_id_svc", ID_PORT, 8'h81);
        cu("t2_cu_svc", 1'b0);
        wr(ID_PORT, 8'h00);
        rd("t2_id_eoi", ID_PORT, 8'h01);
        cu("t2_cu_eoi_edge", 1'b0);
        tick();
        cu("t2_cu_reenter", 1'b1);
        rd("t2_id_next", ID_PORT, 8'h02);
        ack();
        wr(ID_PORT, 8'h00);

        // Committed request survives W1C and mask-off
        IRQ = 4'b1000; tick(); IRQ = '0; repeat (3) tick();
        cu("t3_cu_req", 1'b1);
        rd("t3_id_req", ID_PORT, 8'h03);
        wr(PEND_PORT, 8'h08);
        wr(MASK_PORT, 8'h00);
        cu("t3_cu_committed", 1'b1);
        rd("t3_pend", PEND_PORT, 8'h00);
        rd("t3_mask", MASK_PORT, 8'h00);
        ack();
        cu("t3_cu_ack", 1'b0);
        repeat (3) tick();
        cu("t3_cu_quiet", 1'b0);
        rd("t3_id_svc", ID_PORT, 8'h83);
        wr(ID_PORT, 8'h00);
        tick();
        cu("t3_cu_after_eoi", 1'b0);
        wr(MASK_PORT, 8'h0F);

        // Edges during SERVICE merge; stray ACK/EOI ignored; unmapped writes ignored
        IRQ = 4'b0100; tick(); IRQ = '0; repeat (3) tick();
        ack();
        rd("t4_id_svc", ID_PORT, 8'h82);
        IRQ = 4'b0001; tick(); IRQ = '0; tick(); tick();
        IRQ = 4'b0001; tick(); IRQ = '0; repeat (4) tick();
        rd("t4_pend_merged", PEND_PORT, 8'h01);
        cu("t4_cu_svc", 1'b0);
        wr(ID_PORT, 8'h00);
        cu("t4_cu_eoi_edge", 1'b0);
        tick();
        cu("t4_cu_req", 1'b1);
        rd("t4_id_req", ID_PORT, 8'h00);
        wr(ID_PORT, 8'h00);
        cu("t4_eoi_in_req", 1'b1);
        rd("t4_id_eoi_in_req", ID_PORT, 8'h00);
        ack();
        cu("t4_cu_ack", 1'b0);
        rd("t4_pend_ack", PEND_PORT, 8'h00);
        wr(ID_PORT, 8'h00);
        tick();
        cu("t4_single_request", 1'b0);
        ack();
        cu("t4_stray_ack_cu", 1'b0);
        rd("t4_stray_ack_id", ID_PORT, 8'h00);
        wr(8'h30, 8'hFF);
        rd("t4_unmapped_mask", MASK_PORT, 8'h0F);
        rd("t4_unmapped_rd", 8'h30, 8'h00);
        rd("t4_unmapped_pend", PEND_PORT, 8'h00);

        // Same-edge W1C and new edge on bit 1: set wins
        wr(MASK_PORT, 8'h00);
        IRQ = 4'b0010; tick(); IRQ = '0; repeat (4) tick();
        rd("t5_pend_set", PEND_PORT, 8'h02);
        IRQ = 4'b0010; tick(); IRQ = '0; tick();
        wr(PEND_PORT, 8'h02);
        rd("t5_pend_set_wins", PEND_PORT, 8'h02);
        tick();
        wr(PEND_PORT, 8'h02);
        rd("t5_pend_w1c", PEND_PORT, 8'h00);

        // Reset in SERVICE with IRQ held high
        wr(MASK_PORT, 8'h0F);
        IRQ = 4'hF; tick(); repeat (3) tick();
        cu("t6_cu_req", 1'b1);
        rd("t6_id_req", ID_PORT, 8'h00);
        ack();
        cu("t6_cu_svc", 1'b0);
        rd("t6_id_svc", ID_PORT, 8'h80);
        RESET = 1'b1;
        tick();
        cu("t6_rst_cu", 1'b0);
        rd("t6_rst_mask", MASK_PORT, 8'h00);
        rd("t6_rst_pend", PEND_PORT, 8'h00);
        rd("t6_rst_id", ID_PORT, 8'h00);
        tick();
        RESET = 1'b0;
        tick();
        tick();
        rd("t6_pend_r1", PEND_PORT, 8'h00);
        tick();
        rd("t6_pend_r2", PEND_PORT, 8'h0F);
        cu("t6_cu_masked", 1'b0);
        IRQ = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rat_int_ctrl.md
# rat_int_ctrl

Prioritized interrupt controller that sits between the RAT peripherals and the control unit's INT_CU input. It collects up to eight edge-triggered interrupt sources and masks them. It presents one request at a time to the control unit, holds it until the control unit acknowledges, and blocks further requests until software signals end-of-interrupt through the I/O port space. Software configures the block and reads its status with ordinary OUT/IN instructions on the RAT I/O bus.

## Interface
- N_SRC, 4, number of interrupt sources (1..8); bits at or above N_SRC of every register read as 0 and ignore writes.
- MASK_PORT, 8'h20, port ID of the mask register (read/write).
- PEND_PORT, 8'h21, port ID of the pending register (read; write-1-to-clear).
- ID_PORT, 8'h22, port ID of the active-ID register (read); any write is EOI.

- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  reset, synchronous, active-high. Clock is CLK.
- IRQ  in  N_SRC  asynchronous peripheral requests, rising-edge sensitive; bit 0 has the highest priority.
- PORT_ID  in  8  I/O port address from the CPU.
- OUT_PORT  in  8  write data from the CPU.
- IO_STRB  in  1  one-cycle write strobe from the control unit (OUT instruction).
- INT_ACK  in  1  one-cycle pulse from the control unit when it vectors to the ISR.
- INT_CU  out  1  registered interrupt request to the control unit.
- RD_DATA  out  8  combinational read data for the IN mux.

## Operation
- Synchronizer: a 2-flop synchronizer (s1, s2) plus a delay flop (s3) per source. edge[i] = s2[i] & ~s3[i]. All three flops reset to 0, so an IRQ held high through reset produces one edge after release.
- PEND[i] is set by edge[i] regardless of MASK. It is cleared by a PEND_PORT write with OUT_PORT[i]=1, or by INT_ACK when i is the active ID. If a set and a clear hit the same bit in the same cycle, the set wins.
- MASK: MASK <= OUT_PORT on IO_STRB with PORT_ID==MASK_PORT. 1 = enabled. Reset value is 0 (all disabled).
- eligible = PEND & MASK. The winner is the lowest set index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when eligible != 0. ACTIVE_ID <= winner in the same edge.
  - REQ -> SERVICE on INT_ACK. The same edge clears PEND[ACTIVE_ID].
  - SERVICE -> IDLE on IO_STRB with PORT_ID==ID_PORT (EOI).
- Once in REQ, the request is committed. Masking or W1C-clearing the active source does not withdraw INT_CU; ACK still moves the FSM to SERVICE.
- Ignored events:
  - INT_ACK outside REQ.
  - EOI outside SERVICE.
  - Writes to unmapped ports.
  - Writes to ID_PORT do not change ACTIVE_ID.
- No nesting. New edges during REQ/SERVICE only accumulate in PEND.
- RD_DATA by PORT_ID:
  - MASK_PORT: MASK.
  - PEND_PORT: PEND.
  - ID_PORT: {IN_SVC, 4'b0, ACTIVE_ID[2:0]}, where IN_SVC = (state==SERVICE).
  - Any other port: 8'h00.

## Timing
- Reset values: INT_CU=0, state IDLE, MASK=0, PEND=0, ACTIVE_ID=0, synchronizer flops 0. RD_DATA is 0 at every mapped port.
- IRQ latency, from IRQ[i] first sampled high at edge t0:
  - s1 rises at t0.
  - s2 rises at t0+1.
  - PEND[i] is set at t0+2.
  - The FSM enters REQ at t0+3, and INT_CU is high after t0+3.
  - Total: INT_CU follows 4 edges after IRQ sampling, provided MASK[i]=1 and the FSM is IDLE.
- INT_CU = registered (state==REQ). It falls the cycle after the INT_ACK edge.
- After EOI, an eligible pending source re-enters REQ on the next edge. INT_CU is back high 2 cycles after the EOI strobe cycle.
- IRQ must be low for at least 2 CLK cycles between events to be seen as separate edges. An edge that arrives while PEND is already set is merged.
- Register writes take effect on the edge where IO_STRB is sampled. A read in the following cycle sees the new value.
- RESET asserted in any state returns to IDLE and drops INT_CU on that edge, discarding pending and in-service context.

## Test plan
- Reset, MASK=0: pulse IRQ=4'b0001 -> PEND reads 8'h01, INT_CU stays 0. Write MASK=8'h01 -> INT_CU high 2 edges after the strobe.
- MASK=8'h0F, assert IRQ[2] and IRQ[1] on the same edge -> INT_CU high 4 edges later, ID_PORT reads 8'h01. INT_ACK -> PEND reads 8'h04, ID_PORT reads 8'h81. EOI -> ID reads 8'h02 and INT_CU returns high after 2 cycles.
- In REQ with ACTIVE_ID=3, write PEND_PORT=8'h08 and MASK=0 -> INT_CU stays high. INT_ACK -> SERVICE, INT_CU low, no further request.
- In SERVICE, pulse IRQ[0] twice -> PEND[0] set once. EOI -> one request, ID reads 8'h00. Stray INT_ACK in IDLE and EOI in REQ cause no state change.
- Same-cycle W1C of PEND[1] and new edge[1] -> PEND[1] remains 1.
- Hold IRQ=4'hF through RESET in SERVICE -> INT_CU low on the reset edge, all registers 0. After release, PEND=8'h0F 3 edges later.
